// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver, 16x oversampled from sysclk through a BAUD_DIV tick divider.
// Optional framing check (RX_ERR pulse + BREAK state) is built when UART_RX_FRAME_CHECK_EN is defined.
module uart_receiver #(
   parameter int unsigned BAUD_DIV = 326
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       RX,
   output logic [7:0] RX_DATA,
   output logic       RX_STATUS,
   output logic       RX_ERR
);

`ifdef UART_RX_FRAME_CHECK_EN
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t      state, state_n;
   logic        rx_m, rx_s;
   logic [15:0] tick_cnt;
   logic        tick;
   logic [3:0]  cnt, cnt_n;
   logic [2:0]  num, num_n;
   logic [7:0]  shift, shift_n;
   logic [7:0]  data_n;
   logic        status_n;
`ifdef UART_RX_FRAME_CHECK_EN
   logic        err_n;
`endif

   assign tick = (tick_cnt == 16'(BAUD_DIV - 1));

   always_ff @(posedge sysclk) begin
      if (reset) begin
         rx_m      <= 1'b1;
         rx_s      <= 1'b1;
         tick_cnt  <= '0;
         state     <= IDLE;
         cnt       <= '0;
         num       <= '0;
         shift     <= '0;
         RX_DATA   <= '0;
         RX_STATUS <= 1'b0;
      end else begin
         rx_m      <= RX;
         rx_s      <= rx_m;
         tick_cnt  <= tick ? '0 : tick_cnt + 16'd1;
         state     <= state_n;
         cnt       <= cnt_n;
         num       <= num_n;
         shift     <= shift_n;
         RX_DATA   <= data_n;
         RX_STATUS <= status_n;
      end
   end

`ifdef UART_RX_FRAME_CHECK_EN
   always_ff @(posedge sysclk) begin
      if (reset) RX_ERR <= 1'b0;
      else       RX_ERR <= err_n;
   end
`else
   assign RX_ERR = 1'b0;
`endif

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      num_n    = num;
      shift_n  = shift;
      data_n   = RX_DATA;
      status_n = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
      err_n    = 1'b0;
`endif
      if (tick) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_n = START;
                  cnt_n   = '0;
               end
            end
            START: begin
               cnt_n = cnt + 4'd1;
               // Mid start bit: a line already back high was only a glitch.
               if (cnt == 4'd7) begin
                  if (!rx_s) begin
                     state_n = DATA;
                     cnt_n   = '0;
                     num_n   = '0;
                  end else begin
                     state_n = IDLE;
                  end
               end
            end
            DATA: begin
               cnt_n = cnt + 4'd1;
               if (cnt == 4'd15) begin
                  shift_n[num] = rx_s;
                  if (num == 3'd7) state_n = STOP;
                  else             num_n   = num + 3'd1;
               end
            end
            STOP: begin
               cnt_n = cnt + 4'd1;
               if (cnt == 4'd15) begin
`ifdef UART_RX_FRAME_CHECK_EN
                  if (rx_s) begin
                     data_n   = shift;
                     status_n = 1'b1;
                     state_n  = IDLE;
                  end else begin
                     err_n   = 1'b1;
                     state_n = BREAK;
                  end
`else
                  data_n   = shift;
                  status_n = 1'b1;
                  state_n  = IDLE;
`endif
               end
            end
`ifdef UART_RX_FRAME_CHECK_EN
            BREAK: begin
               if (rx_s) state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver (BAUD_DIV=4, 64 sysclk cycles per bit) using a byte scoreboard.
module tb_uart_receiver;
   localparam int unsigned BAUD_DIV = 4;
   localparam int unsigned BIT_CYC  = 64;

   logic       sysclk = 1'b0;
   logic       reset  = 1'b1;
   logic       RX     = 1'b1;
   logic [7:0] RX_DATA;
   logic       RX_STATUS;
   logic       RX_ERR;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int err_cnt     = 0;
   bit both_hi     = 1'b0;

   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   int         obs_cyc[$];

   uart_receiver #(.BAUD_DIV(BAUD_DIV)) dut (
      .sysclk   (sysclk),
      .reset    (reset),
      .RX       (RX),
      .RX_DATA  (RX_DATA),
      .RX_STATUS(RX_STATUS),
      .RX_ERR   (RX_ERR)
   );

   always #5 sysclk = ~sysclk;

   always @(posedge sysclk) cyc <= cyc + 1;

   always @(negedge sysclk) begin
      if (RX_STATUS === 1'b1) begin
         obs_q.push_back(RX_DATA);
         obs_cyc.push_back(cyc);
      end
      if (RX_ERR === 1'b1) err_cnt++;
      if (RX_STATUS === 1'b1 && RX_ERR === 1'b1) both_hi = 1'b1;
   end

   task automatic idle(input int n);
      RX = 1'b1;
      repeat (n) @(negedge sysclk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      RX = 1'b0;
      repeat (BIT_CYC) @(negedge sysclk);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (BIT_CYC) @(negedge sysclk);
      end
      RX = stop;
      repeat (BIT_CYC) @(negedge sysclk);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      RX    = 1'b1;
      repeat (3) @(negedge sysclk);
      reset = 1'b0;
      vectors++;
      if (RX_DATA !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_data: got %h want 00", RX_DATA);
      end
      vectors++;
      if (RX_STATUS !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_status: got %b want 0", RX_STATUS);
      end
      vectors++;
      if (RX_ERR !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_err: got %b want 0", RX_ERR);
      end
      idle(20);
   endtask

   task automatic test_basic;
      logic [7:0] got, want;
      exp_q.push_back(8'h55);
      send_byte(8'h55, 1'b1);
      idle(16);
      vectors++;
      if (obs_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL basic_count: got %0d pulses want %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         got  = obs_q.pop_front();
         want = exp_q.pop_front();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL basic_data: got %h want %h", got, want);
         end
      end
      vectors++;
      if (RX_DATA !== 8'h55) begin
         miscompares++;
         $display("FAIL basic_hold: got %h want 55", RX_DATA);
      end
      obs_q.delete(); exp_q.delete(); obs_cyc.delete();
   endtask

   task automatic test_glitch;
      logic [7:0] got, want;
      int e0;
      e0 = err_cnt;
      RX = 1'b0;
      repeat (20) @(negedge sysclk);
      idle(200);
      vectors++;
      if (obs_q.size() !== 0) begin
         miscompares++;
         $display("FAIL glitch_status: got %0d pulses want 0", obs_q.size());
      end
      vectors++;
      if (err_cnt - e0 !== 0) begin
         miscompares++;
         $display("FAIL glitch_err: got %0d error pulses want 0", err_cnt - e0);
      end
      obs_q.delete(); obs_cyc.delete();
      exp_q.push_back(8'hA5);
      send_byte(8'hA5, 1'b1);
      idle(16);
      vectors++;
      if (obs_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL glitch_next_count: got %0d pulses want %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         got  = obs_q.pop_front();
         want = exp_q.pop_front();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL glitch_next_data: got %h want %h", got, want);
         end
      end
      obs_q.delete(); exp_q.delete(); obs_cyc.delete();
   endtask

`ifdef UART_RX_FRAME_CHECK_EN
   task automatic test_frame_err;
      logic [7:0] got, want;
      int e0;
      e0 = err_cnt;
      send_byte(8'hA3, 1'b0);
      RX = 1'b0;
      repeat (200) @(negedge sysclk);
      idle(64);
      vectors++;
      if (err_cnt - e0 !== 1) begin
         miscompares++;
         $display("FAIL ferr_pulses: got %0d error pulses want 1", err_cnt - e0);
      end
      vectors++;
      if (obs_q.size() !== 0) begin
         miscompares++;
         $display("FAIL ferr_no_byte: got %0d pulses want 0", obs_q.size());
      end
      vectors++;
      if (RX_DATA !== 8'hA5) begin
         miscompares++;
         $display("FAIL ferr_hold: got %h want a5", RX_DATA);
      end
      obs_q.delete(); obs_cyc.delete();
      exp_q.push_back(8'h3C);
      send_byte(8'h3C, 1'b1);
      idle(16);
      vectors++;
      if (obs_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL ferr_next_count: got %0d pulses want %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         got  = obs_q.pop_front();
         want = exp_q.pop_front();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL ferr_next_data: got %h want %h", got, want);
         end
      end
      obs_q.delete(); exp_q.delete(); obs_cyc.delete();
   endtask
`else
   task automatic test_frame_err;
      logic [7:0] got, want;
      int e0;
      e0 = err_cnt;
      exp_q.push_back(8'hA3);
      send_byte(8'hA3, 1'b0);
      idle(200);
      vectors++;
      if (err_cnt - e0 !== 0) begin
         miscompares++;
         $display("FAIL nochk_err: got %0d error pulses want 0", err_cnt - e0);
      end
      vectors++;
      if (obs_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL nochk_count: got %0d pulses want %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         got  = obs_q.pop_front();
         want = exp_q.pop_front();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL nochk_data: got %h want %h", got, want);
         end
      end
      obs_q.delete(); exp_q.delete(); obs_cyc.delete();
   endtask
`endif

   task automatic test_back_to_back;
      logic [7:0] got, want;
      int gap;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      idle(16);
      vectors++;
      if (obs_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d pulses want %0d", obs_q.size(), exp_q.size());
      end
      if (obs_cyc.size() >= 2) begin
         gap = obs_cyc[1] - obs_cyc[0];
         vectors++;
         if (gap < 636 || gap > 644) begin
            miscompares++;
            $display("FAIL b2b_gap: got %0d cycles want 640+-4", gap);
         end
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         got  = obs_q.pop_front();
         want = exp_q.pop_front();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL b2b_data: got %h want %h", got, want);
         end
      end
      obs_q.delete(); exp_q.delete(); obs_cyc.delete();
   endtask

   task automatic test_reset_mid;
      logic [7:0] got, want;
      logic [7:0] b;
      b  = 8'h81;
      RX = 1'b0;
      repeat (BIT_CYC) @(negedge sysclk);
      for (int i = 0; i < 4; i++) begin
         RX = b[i];
         repeat (BIT_CYC) @(negedge sysclk);
      end
      RX = b[4];
      repeat (BIT_CYC / 2) @(negedge sysclk);
      reset = 1'b1;
      @(negedge sysclk);
      reset = 1'b0;
      RX    = 1'b1;
      vectors++;
      if (RX_DATA !== 8'h00 || RX_STATUS !== 1'b0 || RX_ERR !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_outputs: got data=%h status=%b err=%b want 00/0/0", RX_DATA, RX_STATUS, RX_ERR);
      end
      idle(200);
      vectors++;
      if (obs_q.size() !== 0) begin
         miscompares++;
         $display("FAIL rstmid_aborted: got %0d pulses want 0", obs_q.size());
      end
      obs_q.delete(); obs_cyc.delete();
      exp_q.push_back(8'h7E);
      send_byte(8'h7E, 1'b1);
      idle(16);
      vectors++;
      if (obs_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL rstmid_count: got %0d pulses want %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         got  = obs_q.pop_front();
         want = exp_q.pop_front();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL rstmid_data: got %h want %h", got, want);
         end
      end
      vectors++;
      if (RX_DATA !== 8'h7E) begin
         miscompares++;
         $display("FAIL rstmid_hold: got %h want 7e", RX_DATA);
      end
      obs_q.delete(); exp_q.delete(); obs_cyc.delete();
   endtask

   task automatic test_exclusive;
      vectors++;
      if (both_hi !== 1'b0) begin
         miscompares++;
         $display("FAIL exclusive: got status and err together=%b want 0", both_hi);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_glitch;
      test_frame_err;
      test_back_to_back;
      test_reset_mid;
      test_exclusive;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
